sim_jtag_tap: RTL

//  JTAG TAP responder for simulation: the target end of the sim-side JTAG driver. Oversamples

---
 rtl/sim_jtag_pkg.sv | 53 +++++
 rtl/sim_jtag_tap_fsm.sv | 39 +++
 rtl/sim_jtag_tap.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sim_jtag_pkg.sv
// Shared TAP state encoding, opcodes and the 1149.1 state-transition function.
package sim_jtag_pkg;

    localparam int unsigned IDCODE_OP    = 1;
    localparam int unsigned IDCODE_WIDTH = 32;
    // BYPASS is the all-ones opcode; any opcode that is not IDCODE or USER also selects BYPASS.

    typedef enum logic [3:0] {
        TAP_EX2_DR = 4'h0,
        TAP_EX1_DR = 4'h1,
        TAP_SH_DR  = 4'h2,
        TAP_PA_DR  = 4'h3,
        TAP_SEL_IR = 4'h4,
        TAP_UPD_DR = 4'h5,
        TAP_CAP_DR = 4'h6,
        TAP_SEL_DR = 4'h7,
        TAP_EX2_IR = 4'h8,
        TAP_EX1_IR = 4'h9,
        TAP_SH_IR  = 4'hA,
        TAP_PA_IR  = 4'hB,
        TAP_RTI    = 4'hC,
        TAP_UPD_IR = 4'hD,
        TAP_CAP_IR = 4'hE,
        TAP_TLR    = 4'hF
    } tap_state_e;

    // Standard TMS-driven TAP transition table.
    function automatic tap_state_e next_tap_state(input tap_state_e s, input logic tms);
        tap_state_e n;
        n = TAP_TLR;
        case (s)
            TAP_TLR:    n = tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:    n = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR: n = tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR: n = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:  n = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR: n = tms ? TAP_UPD_DR : TAP_PA_DR;
            TAP_PA_DR:  n = tms ? TAP_EX2_DR : TAP_PA_DR;
            TAP_EX2_DR: n = tms ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR: n = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR: n = tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR: n = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:  n = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR: n = tms ? TAP_UPD_IR : TAP_PA_IR;
            TAP_PA_IR:  n = tms ? TAP_EX2_IR : TAP_PA_IR;
            TAP_EX2_IR: n = tms ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR: n = tms ? TAP_SEL_DR : TAP_RTI;
            default:    n = TAP_TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sim_jtag_tap_fsm.sv
// TAP controller state register, advanced on synchronized TCK rising edges.
module sim_jtag_tap_fsm
    import sim_jtag_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tck_rise,
    input  logic       tms,
    input  logic       trst_n,
    output tap_state_e state,
    output logic       is_tlr_c,
    output logic       is_capture_dr_c,
    output logic       is_shift_dr_c,
    output logic       is_update_dr_c,
    output logic       is_capture_ir_c,
    output logic       is_shift_ir_c,
    output logic       is_update_ir_c
);

    // Test reset wins over any TCK edge seen on the same clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= TAP_TLR;
        end else if (!trst_n) begin
            state <= TAP_TLR;
        end else if (tck_rise) begin
            state <= next_tap_state(state, tms);
        end
    end

    assign is_tlr_c        = (state == TAP_TLR);
    assign is_capture_dr_c = (state == TAP_CAP_DR);
    assign is_shift_dr_c   = (state == TAP_SH_DR);
    assign is_update_dr_c  = (state == TAP_UPD_DR);
    assign is_capture_ir_c = (state == TAP_CAP_IR);
    assign is_shift_ir_c   = (state == TAP_SH_IR);
    assign is_update_ir_c  = (state == TAP_UPD_IR);

endmodule

// File: rtl/sim_jtag_tap.sv
// Simulation JTAG TAP target: oversampled JTAG pins, IDCODE/BYPASS/USER data registers,
// and a valid/ready port that hands USER updates to the SoC.
module sim_jtag_tap
    import sim_jtag_pkg::*;
#(
    parameter int unsigned            IR_WIDTH    = 5,
    parameter logic [31:0]            IDCODE_VAL  = 32'h0000_0001,
    parameter logic [IR_WIDTH-1:0]    USER_IR     = IR_WIDTH'(16),
    parameter int unsigned            USER_WIDTH  = 41,
    parameter int unsigned            SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  jtag_TCK,
    input  logic                  jtag_TMS,
    input  logic                  jtag_TDI,
    input  logic                  jtag_TRSTn,
    output logic                  jtag_TDO_data,
    output logic                  jtag_TDO_driven,
    output logic                  user_update_valid,
    output logic [USER_WIDTH-1:0] user_update_data,
    input  logic                  user_update_ready,
    input  logic [USER_WIDTH-1:0] user_capture_data,
    output logic                  user_overrun,
    output logic [3:0]            tap_state
);

    localparam logic [IR_WIDTH-1:0] IDCODE_IR = IR_WIDTH'(IDCODE_OP);

    logic [SYNC_STAGES-1:0]  tck_sync;
    logic [SYNC_STAGES-1:0]  tms_sync;
    logic [SYNC_STAGES-1:0]  tdi_sync;
    logic [SYNC_STAGES-1:0]  trst_sync;
    logic                    tck_q;
    logic                    tck_s;
    logic                    tms_s;
    logic                    tdi_s;
    logic                    trst_n_s;
    logic                    tck_rise_c;
    logic                    tck_fall_c;

    tap_state_e              state;
    logic                    is_tlr_c;
    logic                    is_capture_dr_c;
    logic                    is_shift_dr_c;
    logic                    is_update_dr_c;
    logic                    is_capture_ir_c;
    logic                    is_shift_ir_c;
    logic                    is_update_ir_c;

    logic [IR_WIDTH-1:0]     ir;
    logic [IR_WIDTH-1:0]     ir_sr;
    logic [IDCODE_WIDTH-1:0] idcode_sr;
    logic                    bypass_sr;
    logic [USER_WIDTH-1:0]   user_sr;
    logic                    sel_idcode_c;
    logic                    sel_user_c;
    logic                    dr_lsb_c;
    logic                    user_update_c;
    logic                    user_accept_c;

    // Identical synchronizer chains so TMS/TDI line up with the TCK edge they belong to.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tck_sync  <= '0;
            tms_sync  <= '0;
            tdi_sync  <= '0;
            trst_sync <= '0;
            tck_q     <= 1'b0;
        end else begin
            tck_sync  <= {tck_sync[SYNC_STAGES-2:0], jtag_TCK};
            tms_sync  <= {tms_sync[SYNC_STAGES-2:0], jtag_TMS};
            tdi_sync  <= {tdi_sync[SYNC_STAGES-2:0], jtag_TDI};
            trst_sync <= {trst_sync[SYNC_STAGES-2:0], jtag_TRSTn};
            tck_q     <= tck_sync[SYNC_STAGES-1];
        end
    end

    assign tck_s      = tck_sync[SYNC_STAGES-1];
    assign tms_s      = tms_sync[SYNC_STAGES-1];
    assign tdi_s      = tdi_sync[SYNC_STAGES-1];
    assign trst_n_s   = trst_sync[SYNC_STAGES-1];
    assign tck_rise_c = tck_s & ~tck_q;
    assign tck_fall_c = ~tck_s & tck_q;

    sim_jtag_tap_fsm u_fsm (
        .clock           (clock),
        .reset_n         (reset_n),
        .tck_rise        (tck_rise_c),
        .tms             (tms_s),
        .trst_n          (trst_n_s),
        .state           (state),
        .is_tlr_c        (is_tlr_c),
        .is_capture_dr_c (is_capture_dr_c),
        .is_shift_dr_c   (is_shift_dr_c),
        .is_update_dr_c  (is_update_dr_c),
        .is_capture_ir_c (is_capture_ir_c),
        .is_shift_ir_c   (is_shift_ir_c),
        .is_update_ir_c  (is_update_ir_c)
    );

    assign tap_state    = state;
    assign sel_idcode_c = (ir == IDCODE_IR);
    assign sel_user_c   = (ir == USER_IR);
    assign dr_lsb_c     = sel_idcode_c ? idcode_sr[0] : (sel_user_c ? user_sr[0] : bypass_sr);

    // Instruction register: capture/shift on rise, load on UPDATE_IR fall, forced by TLR/TRST.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ir    <= IDCODE_IR;
            ir_sr <= '0;
        end else if (!trst_n_s) begin
            ir    <= IDCODE_IR;
        end else if (tck_rise_c) begin
            if (is_capture_ir_c) ir_sr <= IR_WIDTH'(2'b01);
            if (is_shift_ir_c)   ir_sr <= {tdi_s, ir_sr[IR_WIDTH-1:1]};
            if (is_tlr_c)        ir    <= IDCODE_IR;
        end else if (tck_fall_c && is_update_ir_c) begin
            ir <= ir_sr;
        end
    end

    // Data registers: capture and shift only the one selected by the current instruction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idcode_sr <= '0;
            bypass_sr <= 1'b0;
            user_sr   <= '0;
        end else if (trst_n_s && tck_rise_c) begin
            if (is_capture_dr_c) begin
                if (sel_idcode_c)    idcode_sr <= IDCODE_VAL;
                else if (sel_user_c) user_sr   <= user_capture_data;
                else                 bypass_sr <= 1'b0;
            end
            if (is_shift_dr_c) begin
                if (sel_idcode_c)    idcode_sr <= {tdi_s, idcode_sr[IDCODE_WIDTH-1:1]};
                else if (sel_user_c) user_sr   <= {tdi_s, user_sr[USER_WIDTH-1:1]};
                else                 bypass_sr <= tdi_s;
            end
        end
    end

    // TDO changes on the falling TCK edge so the host samples it on the next rise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            jtag_TDO_data   <= 1'b0;
            jtag_TDO_driven <= 1'b0;
        end else if (!trst_n_s) begin
            jtag_TDO_driven <= 1'b0;
        end else if (tck_fall_c) begin
            jtag_TDO_data   <= is_shift_ir_c ? ir_sr[0] : dr_lsb_c;
            jtag_TDO_driven <= is_shift_dr_c | is_shift_ir_c;
        end
    end

    assign user_update_c = trst_n_s && tck_fall_c && is_update_dr_c && sel_user_c;
    assign user_accept_c = user_update_valid && user_update_ready;

    // USER update handshake; an update arriving while one is still pending is dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            user_update_valid <= 1'b0;
            user_update_data  <= '0;
            user_overrun      <= 1'b0;
        end else begin
            if (user_update_c && (!user_update_valid || user_accept_c)) begin
                user_update_data  <= user_sr;
                user_update_valid <= 1'b1;
            end else if (user_accept_c) begin
                user_update_valid <= 1'b0;
            end
            if (user_update_c && user_update_valid && !user_accept_c) begin
                user_overrun <= 1'b1;
            end
        end
    end

endmodule
